// File: rtl/mmm_output_framer_if.sv
// Stream bundle between the matrix-multiply core, the output framer and the downstream sink.
// slave is the framer's view; master is the surrounding environment's view.
interface mmm_output_framer_if #(
  parameter int OUTW = 32,
  parameter int OW   = 16
);
  logic [OUTW-1:0] S_AXIS_TDATA;
  logic            S_AXIS_TVALID;
  logic            S_AXIS_TREADY;
  logic [OW-1:0]   M_AXIS_TDATA;
  logic            M_AXIS_TVALID;
  logic            M_AXIS_TREADY;
  logic            M_AXIS_TLAST;
  logic            M_AXIS_TUSER;

  modport slave (
    input  S_AXIS_TDATA, S_AXIS_TVALID, M_AXIS_TREADY,
    output S_AXIS_TREADY, M_AXIS_TDATA, M_AXIS_TVALID, M_AXIS_TLAST, M_AXIS_TUSER
  );

  modport master (
    output S_AXIS_TDATA, S_AXIS_TVALID, M_AXIS_TREADY,
    input  S_AXIS_TREADY, M_AXIS_TDATA, M_AXIS_TVALID, M_AXIS_TLAST, M_AXIS_TUSER
  );
endinterface

// File: rtl/mmm_output_framer.sv
// Scales/saturates core results to OW bits and adds row/matrix flags; FRAMER_ROUND_EN selects rounding.
// Latency 1 cycle into an empty buffer; 2-entry skid buffer, ready depends only on registered state.
module mmm_output_framer #(
  parameter int OUTW  = 32,
  parameter int OW    = 16,
  parameter int M     = 7,
  parameter int N     = 9,
  parameter int SHIFT = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  mmm_output_framer_if.slave   axis,
  output logic [15:0]          sat_count
);

  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam int RW = (M > 1) ? $clog2(M) : 1;

  localparam logic [1:0] EMPTY = 2'b00;
  localparam logic [1:0] ONE   = 2'b10;
  localparam logic [1:0] FULL  = 2'b11;

  localparam logic signed [OUTW:0] MAXV = {{(OUTW-OW+2){1'b0}}, {(OW-1){1'b1}}};
  localparam logic signed [OUTW:0] MINV = {{(OUTW-OW+2){1'b1}}, {(OW-1){1'b0}}};
`ifdef FRAMER_ROUND_EN
  localparam logic signed [OUTW:0] RND = (SHIFT == 0) ? '0 : ((OUTW+1)'(1) << (SHIFT - 1));
`endif

  // state_q[1] is the main-entry valid bit, state_q[0] the skid-entry valid bit
  logic [1:0]      state_q, state_d;
  logic [OW-1:0]   main_dat_q, main_dat_d, skid_dat_q, skid_dat_d;
  logic            main_last_q, main_last_d, skid_last_q, skid_last_d;
  logic            main_user_q, main_user_d, skid_user_q, skid_user_d;
  logic [CW-1:0]   col_q, col_d;
  logic [RW-1:0]   row_q, row_d;
  logic [15:0]     sat_count_q, sat_count_d;

  logic                   s_rdy, acc, drain;
  logic signed [OUTW:0]   ext, ext_r, shifted;
  logic                   sat_hi, sat_lo;
  logic [OW-1:0]          beat_dat;
  logic                   col_last, row_last, beat_last, beat_user;

  assign s_rdy = reset & ~state_q[0];
  assign acc   = axis.S_AXIS_TVALID & s_rdy;
  assign drain = state_q[1] & axis.M_AXIS_TREADY;

  always_comb begin
    ext = {axis.S_AXIS_TDATA[OUTW-1], axis.S_AXIS_TDATA};
`ifdef FRAMER_ROUND_EN
    ext_r = ext + RND;
`else
    ext_r = ext;
`endif
    shifted  = ext_r >>> SHIFT;
    sat_hi   = (shifted > MAXV);
    sat_lo   = (shifted < MINV);
    beat_dat = sat_hi ? MAXV[OW-1:0] : (sat_lo ? MINV[OW-1:0] : shifted[OW-1:0]);

    col_last  = (col_q == CW'(N - 1));
    row_last  = (row_q == RW'(M - 1));
    beat_last = col_last;
    beat_user = col_last & row_last;
  end

  always_comb begin
    col_d       = col_q;
    row_d       = row_q;
    sat_count_d = sat_count_q;
    if (acc) begin
      if (col_last) begin
        col_d = '0;
        row_d = row_last ? '0 : row_q + RW'(1);
      end else begin
        col_d = col_q + CW'(1);
      end
      if ((sat_hi || sat_lo) && (sat_count_q != 16'hFFFF))
        sat_count_d = sat_count_q + 16'd1;
    end
  end

  always_comb begin
    state_d     = state_q;
    main_dat_d  = main_dat_q;
    main_last_d = main_last_q;
    main_user_d = main_user_q;
    skid_dat_d  = skid_dat_q;
    skid_last_d = skid_last_q;
    skid_user_d = skid_user_q;
    case (state_q)
      EMPTY: begin
        if (acc) begin
          state_d     = ONE;
          main_dat_d  = beat_dat;
          main_last_d = beat_last;
          main_user_d = beat_user;
        end
      end
      ONE: begin
        if (acc && drain) begin
          main_dat_d  = beat_dat;
          main_last_d = beat_last;
          main_user_d = beat_user;
        end else if (acc) begin
          state_d     = FULL;
          skid_dat_d  = beat_dat;
          skid_last_d = beat_last;
          skid_user_d = beat_user;
        end else if (drain) begin
          state_d = EMPTY;
        end
      end
      FULL: begin
        // ready is low here, so only the skid-to-main move can happen
        if (drain) begin
          state_d     = ONE;
          main_dat_d  = skid_dat_q;
          main_last_d = skid_last_q;
          main_user_d = skid_user_q;
        end
      end
      default: state_d = EMPTY;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= EMPTY;
      main_dat_q  <= '0;
      main_last_q <= 1'b0;
      main_user_q <= 1'b0;
      skid_dat_q  <= '0;
      skid_last_q <= 1'b0;
      skid_user_q <= 1'b0;
      col_q       <= '0;
      row_q       <= '0;
      sat_count_q <= '0;
    end else begin
      state_q     <= state_d;
      main_dat_q  <= main_dat_d;
      main_last_q <= main_last_d;
      main_user_q <= main_user_d;
      skid_dat_q  <= skid_dat_d;
      skid_last_q <= skid_last_d;
      skid_user_q <= skid_user_d;
      col_q       <= col_d;
      row_q       <= row_d;
      sat_count_q <= sat_count_d;
    end
  end

  assign axis.S_AXIS_TREADY = s_rdy;
  assign axis.M_AXIS_TVALID = state_q[1];
  assign axis.M_AXIS_TDATA  = main_dat_q;
  assign axis.M_AXIS_TLAST  = main_last_q;
  assign axis.M_AXIS_TUSER  = main_user_q;
  assign sat_count          = sat_count_q;

endmodule

// File: tb/tb_mmm_output_framer.sv
// Directed bench for mmm_output_framer with a queue scoreboard fed from observed input accepts.
// Honours FRAMER_ROUND_EN in its reference model.
module tb_mmm_output_framer;
  localparam int SHIFT = 8;

  logic        clk;
  logic        reset;
  logic [15:0] sat_count;

  mmm_output_framer_if #(.OUTW(32), .OW(16)) vif();

  mmm_output_framer #(.OUTW(32), .OW(16), .M(7), .N(9), .SHIFT(SHIFT)) dut (
    .clk       (clk),
    .reset     (reset),
    .axis      (vif),
    .sat_count (sat_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] dat;
    logic        last;
    logic        user;
    int          cyc;
  } exp_t;

  exp_t        q[$];
  int          total = 0;
  int          bad = 0;
  int          cyc = 0;
  int          acc_cnt = 0;
  int          mcol = 0, mrow = 0;
  logic [15:0] msat = '0;
  int          out_idx = 0, cnt_last = 0, cnt_user = 0, first_last = 0, first_user = 0;
  logic        prev_stall = 1'b0;
  logic [17:0] prev_word = '0;
  logic [15:0] last_out = '0;
  logic        lat_chk = 1'b0;

`ifdef FRAMER_ROUND_EN
  localparam logic [15:0] EXP_POS = 16'h0124;
  localparam logic [15:0] EXP_NEG = 16'h0000;
`else
  localparam logic [15:0] EXP_POS = 16'h0123;
  localparam logic [15:0] EXP_NEG = 16'hFFFF;
`endif

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] scale(input logic [31:0] d, output logic sat);
    longint v;
    v = longint'($signed(d));
`ifdef FRAMER_ROUND_EN
    v = v + (longint'(1) << (SHIFT - 1));
`endif
    v = v >>> SHIFT;
    sat = 1'b0;
    if (v > 32767) begin
      v = 32767;
      sat = 1'b1;
    end else if (v < -32768) begin
      v = -32768;
      sat = 1'b1;
    end
    return v[15:0];
  endfunction

  // Monitor: compare completed output transfers, then record new input accepts.
  always @(negedge clk) begin
    exp_t e;
    logic sat;
    cyc++;
    if (!reset) begin
      q.delete();
      mcol = 0; mrow = 0; msat = '0;
      out_idx = 0; cnt_last = 0; cnt_user = 0; first_last = 0; first_user = 0;
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        check("hold_valid", {31'd0, vif.M_AXIS_TVALID}, 32'd1);
        check("hold_beat", {14'd0, vif.M_AXIS_TUSER, vif.M_AXIS_TLAST, vif.M_AXIS_TDATA}, {14'd0, prev_word});
      end
      if (vif.M_AXIS_TVALID && vif.M_AXIS_TREADY) begin
        if (q.size() == 0) begin
          check("spurious_out", {31'd0, vif.M_AXIS_TVALID}, 32'd0);
        end else begin
          e = q.pop_front();
          out_idx++;
          last_out = vif.M_AXIS_TDATA;
          if (vif.M_AXIS_TLAST) begin
            cnt_last++;
            if (first_last == 0) first_last = out_idx;
          end
          if (vif.M_AXIS_TUSER) begin
            cnt_user++;
            if (first_user == 0) first_user = out_idx;
          end
          check("out_data", {16'd0, vif.M_AXIS_TDATA}, {16'd0, e.dat});
          check("out_tlast", {31'd0, vif.M_AXIS_TLAST}, {31'd0, e.last});
          check("out_tuser", {31'd0, vif.M_AXIS_TUSER}, {31'd0, e.user});
          if (lat_chk) check("latency", cyc - e.cyc, 32'd1);
        end
      end
      prev_stall = vif.M_AXIS_TVALID && !vif.M_AXIS_TREADY;
      prev_word  = {vif.M_AXIS_TUSER, vif.M_AXIS_TLAST, vif.M_AXIS_TDATA};
      if (vif.S_AXIS_TVALID && vif.S_AXIS_TREADY) begin
        e.dat  = scale(vif.S_AXIS_TDATA, sat);
        e.last = (mcol == 8);
        e.user = (mcol == 8) && (mrow == 6);
        e.cyc  = cyc;
        q.push_back(e);
        acc_cnt++;
        if (sat && msat != 16'hFFFF) msat = msat + 16'd1;
        if (mcol == 8) begin
          mcol = 0;
          mrow = (mrow == 6) ? 0 : mrow + 1;
        end else begin
          mcol = mcol + 1;
        end
      end
    end
  end

  // Called at posedge+1; returns at posedge+1 right after the beat is accepted.
  task automatic send(input logic [31:0] d);
    int n;
    logic ok;
    n = 0;
    ok = 1'b0;
    vif.S_AXIS_TDATA  = d;
    vif.S_AXIS_TVALID = 1'b1;
    while (!ok && n < 100) begin
      @(negedge clk);
      ok = vif.S_AXIS_TREADY;
      n++;
      @(posedge clk);
      #1;
    end
    if (!ok) check("send_timeout", {31'd0, ok}, 32'd1);
    vif.S_AXIS_TVALID = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    @(negedge clk);
    @(posedge clk);
    #1;
    reset = 1'b1;
  endtask

  initial begin
    logic [31:0] d;
    logic        acc;
    int          base, n;

    reset = 1'b0;
    vif.S_AXIS_TDATA  = '0;
    vif.S_AXIS_TVALID = 1'b0;
    vif.M_AXIS_TREADY = 1'b1;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("rst_s_tready", {31'd0, vif.S_AXIS_TREADY}, 32'd0);
    check("rst_m_tvalid", {31'd0, vif.M_AXIS_TVALID}, 32'd0);
    check("rst_m_tdata", {16'd0, vif.M_AXIS_TDATA}, 32'd0);
    check("rst_sat_count", {16'd0, sat_count}, 32'd0);
    reset = 1'b1;
    #1;
    check("rel_s_tready", {31'd0, vif.S_AXIS_TREADY}, 32'd1);
    @(posedge clk);
    #1;

    // Truncation / rounding
    send(32'h000123C0);
    @(posedge clk); #1;
    check("scale_pos", {16'd0, last_out}, {16'd0, EXP_POS});
    send(32'hFFFFFF80);
    @(posedge clk); #1;
    check("scale_neg", {16'd0, last_out}, {16'd0, EXP_NEG});
    check("sat_count_zero", {16'd0, sat_count}, 32'd0);

    // Saturation
    send(32'h7FFFFFFF);
    @(posedge clk); #1;
    check("sat_pos", {16'd0, last_out}, 32'h00007FFF);
    send(32'h80000000);
    @(posedge clk); #1;
    check("sat_neg", {16'd0, last_out}, 32'h00008000);
    check("sat_count_two", {16'd0, sat_count}, 32'd2);

    // Framing: 64 back-to-back beats from a clean matrix start
    do_reset();
    @(posedge clk); #1;
    lat_chk = 1'b1;
    for (int i = 0; i < 64; i++) begin
      d = (i % 3 == 0) ? $urandom : $urandom_range(0, 32'h00FFFFFF);
      send(d);
    end
    @(posedge clk); #1;
    lat_chk = 1'b0;
    check("frame_outputs", out_idx, 32'd64);
    check("frame_tlast_cnt", cnt_last, 32'd7);
    check("frame_tuser_cnt", cnt_user, 32'd1);
    check("frame_first_tuser", first_user, 32'd63);

    // Backpressure: continuous valid, downstream stalled for 5 cycles
    base = acc_cnt;
    d = 32'h00011100;
    vif.M_AXIS_TREADY = 1'b0;
    vif.S_AXIS_TDATA  = d;
    vif.S_AXIS_TVALID = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      acc = vif.S_AXIS_TREADY;
      @(posedge clk); #1;
      if (acc) begin
        d = d + 32'h00000100;
        vif.S_AXIS_TDATA = d;
      end
    end
    check("bp_accepts", acc_cnt - base, 32'd2);
    check("bp_s_tready_low", {31'd0, vif.S_AXIS_TREADY}, 32'd0);
    vif.S_AXIS_TVALID = 1'b0;
    vif.M_AXIS_TREADY = 1'b1;
    @(negedge clk);
    check("bp_drain_1", {31'd0, vif.M_AXIS_TVALID}, 32'd1);
    @(negedge clk);
    check("bp_drain_2", {31'd0, vif.M_AXIS_TVALID}, 32'd1);
    @(negedge clk);
    check("bp_drain_empty", {31'd0, vif.M_AXIS_TVALID}, 32'd0);
    @(posedge clk); #1;

    // Reset mid-matrix
    for (int i = 0; i < 20; i++) send(32'h00001000 + 32'(i) * 32'h100);
    #2;
    reset = 1'b0;
    #1;
    check("arst_m_tvalid", {31'd0, vif.M_AXIS_TVALID}, 32'd0);
    check("arst_m_tdata", {16'd0, vif.M_AXIS_TDATA}, 32'd0);
    check("arst_m_tlast", {31'd0, vif.M_AXIS_TLAST}, 32'd0);
    check("arst_s_tready", {31'd0, vif.S_AXIS_TREADY}, 32'd0);
    check("arst_sat_count", {16'd0, sat_count}, 32'd0);
    @(negedge clk);
    #2;
    reset = 1'b1;
    @(posedge clk); #1;
    for (int i = 0; i < 63; i++) send(32'h00002000 + 32'(i) * 32'h80);
    @(posedge clk); #1;
    check("arst_first_tlast", first_last, 32'd9);
    check("arst_first_tuser", first_user, 32'd63);

    // Drain and final state
    n = 0;
    while (q.size() != 0 && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    check("queue_empty", q.size(), 32'd0);
    check("final_sat_count", {16'd0, sat_count}, {16'd0, msat});

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/mmm_output_framer.md
# mmm_output_framer

Downstream stage of the matrix-multiply core. Consumes its OUTPUT AXI-Stream of signed OUTW-bit dot products, which arrive row-major, M rows × N columns per result matrix. Each result is scaled by an arithmetic right shift and saturated to OW bits. Results are re-emitted on a narrower AXI-Stream with row and matrix framing flags. A 2-entry skid buffer provides full throughput with registered outputs.

## Interface
- OUTW, 32: input result width (signed, two's complement)
- OW, 16: output width (signed); OW ≤ OUTW
- M, 7: rows per result matrix
- N, 9: columns per result matrix
- SHIFT, 8: arithmetic right-shift amount, 0 ≤ SHIFT < OUTW
- clk  in  1  single clock, rising edge
- reset  in  1  asynchronous, active-low reset
- S_AXIS_TDATA  in  OUTW  result from upstream core
- S_AXIS_TVALID  in  1  upstream valid
- S_AXIS_TREADY  out  1  block can accept a beat
- M_AXIS_TDATA  out  OW  scaled, saturated result
- M_AXIS_TVALID  out  1  output valid
- M_AXIS_TREADY  in  1  downstream ready
- M_AXIS_TLAST  out  1  beat is last column of a row (col == N-1)
- M_AXIS_TUSER  out  1  beat is last element of the matrix (row == M-1 and col == N-1)
- sat_count  out  16  count of saturated beats since reset; sticks at 0xFFFF

## Operation
**Transfers**
- Input accept = S_AXIS_TVALID & S_AXIS_TREADY.
- Output transfer = M_AXIS_TVALID & M_AXIS_TREADY.

**Scaling, per accepted beat**
- Take the (OUTW+1)-bit sign-extended input and optionally add the rounding term (see Configuration).
- Arithmetic shift right by SHIFT.
- Clamp to [-2^(OW-1), 2^(OW-1)-1].
- A clamp event increments sat_count, unless sat_count is 0xFFFF.

**Framing counters**
- col (0..N-1) and row (0..M-1) advance on input accept only.
- col wraps to 0 at N-1, and row increments when it does.
- row wraps to 0 at M-1 when col also wraps.
- TLAST and TUSER are computed from the counters at accept time and travel with the data.

**Buffering**
- There are two entries: main (drives M_AXIS_*) and skid.
- Accept when main is empty, or main is being drained the same cycle: load main.
- Accept when main is full and not draining: load skid.
- Main drains while skid is full: skid moves to main the same edge.
- S_AXIS_TREADY = reset & !skid_valid. This is a registered-state term, with no combinational path from M_AXIS_TREADY.
- Output order always equals input order. No beat is dropped or duplicated.

**Control state**
- States, derived from (main_valid, skid_valid): EMPTY (0,0), ONE (1,0), FULL (1,1). (0,1) is illegal.
- EMPTY → ONE on accept.
- ONE → FULL on accept without drain.
- ONE → EMPTY on drain without accept.
- FULL → ONE on drain. No accept is possible in FULL.

## Timing
- **Reset (asserted):** all outputs are 0, including S_AXIS_TREADY and sat_count. Counters and buffer valid bits are cleared.
- **Reset deassertion:** S_AXIS_TREADY = 1 immediately, since the buffer is empty.
- **Latency:** 1 cycle from input accept to M_AXIS_TVALID, when main was empty.
- **Throughput:** 1 beat/cycle sustained while M_AXIS_TREADY = 1.
- **Backpressure:** with M_AXIS_TREADY held low, at most 2 beats are accepted. S_AXIS_TREADY falls on the edge that loads skid.
- **Once asserted,** M_AXIS_TVALID, TDATA, TLAST and TUSER hold stable until transfer.
- **Simultaneous accept and drain in ONE:** stays ONE. New data enters main; skid stays empty.
- **Reset mid-matrix:** the in-flight beats are discarded. The next accepted beat is row 0, col 0.

## Configuration
- FRAMER_ROUND_EN defined: add 2^(SHIFT-1) before the shift (round half toward +∞). When SHIFT = 0, no term is added.
- Not defined: pure truncation (floor) by arithmetic shift.
- Saturation applies in both cases, after rounding.

## Test plan
- **Truncation/rounding:** defaults, input 0x000123C0 → output 0x0123 without FRAMER_ROUND_EN, 0x0124 with it. Input 0xFFFFFF80 → 0xFFFF truncated, 0x0000 rounded. sat_count stays 0.
- **Saturation:** inputs 0x7FFFFFFF, then 0x80000000 → outputs 0x7FFF, then 0x8000; sat_count = 2.
- **Framing:** stream 63 beats, then 1 more with M_AXIS_TREADY = 1.
  - TLAST on beats 9, 18, …, 63; TUSER only on beat 63.
  - Beat 64 has TLAST = TUSER = 0. Output i appears 1 cycle after accept i.
- **Backpressure:** continuous TVALID, M_AXIS_TREADY low for 5 cycles.
  - Exactly 2 beats accepted; S_AXIS_TREADY low from the cycle after the 2nd accept.
  - On release, data emerges in order with no gaps and no loss.
- **Reset mid-matrix:** after 20 accepted beats, pulse reset low asynchronously between edges.
  - Outputs go to 0 at once.
  - After release, the 9th beat carries TLAST, and TUSER first appears on the 63rd beat.
